// File: rtl/decode_pkg.sv
// Shared opcode constants, format classes and the decoded-slot record for the
// RV32I decode stage.
package decode_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;

  // Slots store the PC at its widest supported size; narrower PCs are zero-extended.
  localparam int PC_MAX_W = 32;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic [31:0]         insn;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [31:0]         imm;
    fmt_e                fmt;
    logic                illegal;
  } decoded_t;

  localparam decoded_t DECODED_RST = '{
    pc: '0, insn: '0, opcode: '0, rd: '0, rs1: '0, rs2: '0,
    funct3: '0, funct7: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0
  };

endpackage

// File: rtl/imm_gen.sv
// Combinational format classifier and sign-extended immediate builder for
// one RV32I instruction word.
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] insn,
  output fmt_e        fmt,
  output logic [31:0] imm,
  output logic        illegal
);

  always_comb begin
    fmt     = FMT_NONE;
    imm     = '0;
    illegal = 1'b0;
    // Compressed or reserved encodings never match a 32-bit opcode.
    if (insn[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (insn[6:0])
        OP_LUI, OP_AUIPC: begin
          fmt = FMT_U;
          imm = {insn[31:12], 12'b0};
        end
        OP_JAL: begin
          fmt = FMT_J;
          imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        end
        OP_JALR, OP_LOAD, OP_OP_IMM, OP_MISC_MEM, OP_SYSTEM: begin
          fmt = FMT_I;
          imm = {{20{insn[31]}}, insn[31:20]};
        end
        OP_STORE: begin
          fmt = FMT_S;
          imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
        end
        OP_BRANCH: begin
          fmt = FMT_B;
          imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        end
        OP_OP: begin
          fmt = FMT_R;
        end
        default: begin
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetch's {pc, insn} on the input path and holds
// results in a registered OUT slot backed by a one-entry SKID slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [31:0]       imm_o,
  output logic [2:0]        fmt_o,
  output logic              illegal_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid_o and its payload stay put until ready_i takes them, and
  // ready_o is a flop so fetch never sees a combinational path from ready_i.

  decoded_t   dec_in;
  decoded_t   out_q, out_d;
  decoded_t   skid_q, skid_d;
  logic       out_v_q, out_v_d;
  logic       skid_v_q, skid_v_d;
  logic       ready_q;
  logic       acc;
  logic       load_out;
  fmt_e       gen_fmt;
  logic [31:0] gen_imm;
  logic        gen_illegal;
  logic [31:0] insn_w;

  assign insn_w = 32'(insn_i);

  imm_gen u_imm_gen (
    .insn    (insn_w),
    .fmt     (gen_fmt),
    .imm     (gen_imm),
    .illegal (gen_illegal)
  );

  always_comb begin
    dec_in         = DECODED_RST;
    dec_in.pc      = PC_MAX_W'(pc_i);
    dec_in.insn    = insn_w;
    dec_in.opcode  = insn_w[6:0];
    dec_in.rd      = insn_w[11:7];
    dec_in.rs1     = insn_w[19:15];
    dec_in.rs2     = insn_w[24:20];
    dec_in.funct3  = insn_w[14:12];
    dec_in.funct7  = insn_w[31:25];
    dec_in.imm     = gen_imm;
    dec_in.fmt     = gen_fmt;
    dec_in.illegal = gen_illegal;
  end

  assign acc      = valid_i & ready_q;
  assign load_out = ~out_v_q | ready_i;

  // OUT always holds the older entry; SKID only fills while OUT is stalled.
  always_comb begin
    out_d    = out_q;
    skid_d   = skid_q;
    out_v_d  = out_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (load_out) begin
      if (skid_v_q) begin
        out_d    = skid_q;
        out_v_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        if (acc) out_d = dec_in;
        out_v_d = acc;
      end
    end else if (acc) begin
      skid_d   = dec_in;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q    <= DECODED_RST;
      skid_q   <= DECODED_RST;
      out_v_q  <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      out_q    <= out_d;
      skid_q   <= skid_d;
      out_v_q  <= out_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= ~skid_v_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = out_v_q;
  assign pc_o      = out_q.pc[AWIDTH-1:0];
  assign insn_o    = out_q.insn[DWIDTH-1:0];
  assign opcode_o  = out_q.opcode;
  assign rd_o      = out_q.rd;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign imm_o     = out_q.imm;
  assign fmt_o     = out_q.fmt;
  assign illegal_o = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed test-plan vectors, then randomized traffic
// checked against a transaction-level queue model of the two-entry pipe.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i, illegal_o;
  logic [31:0] pc_i, insn_i, pc_o, insn_o, imm_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [4:0]  rd_o, rs1_o, rs2_o;
  logic [2:0]  funct3_o, fmt_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];   // {pc, insn} of every instruction held in the stage
  logic [31:0] got_q[$];
  logic [6:0]  ops[11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                           7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
  logic        a, x;
  logic [63:0] pp;
  int          idx;

  decode_stage #(.AWIDTH(32), .DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .insn_i(insn_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .imm_o(imm_o), .fmt_o(fmt_o), .illegal_o(illegal_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA rules, using arithmetic shifts for sign extension.
  function automatic void ref_decode(input logic [31:0] insn, output logic [2:0] fmt,
                                     output logic [31:0] imm, output logic ill);
    logic signed [31:0] s;
    logic [31:0] sgn, i_imm, hi7;
    s     = insn;
    sgn   = s >>> 31;
    i_imm = s >>> 20;
    hi7   = s >>> 25;
    fmt   = FMT_NONE;
    imm   = 32'd0;
    ill   = 1'b0;
    if (insn[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (insn[6:0])
        7'h37, 7'h17: begin fmt = FMT_U; imm = insn & 32'hFFFF_F000; end
        7'h6F: begin
          fmt = FMT_J;
          imm = (sgn << 20) | (32'(insn[19:12]) << 12) | (32'(insn[20]) << 11)
              | (32'(insn[30:21]) << 1);
        end
        7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin fmt = FMT_I; imm = i_imm; end
        7'h23: begin fmt = FMT_S; imm = (hi7 << 5) | 32'(insn[11:7]); end
        7'h63: begin
          fmt = FMT_B;
          imm = (sgn << 12) | (32'(insn[7]) << 11) | (32'(insn[30:25]) << 5)
              | (32'(insn[11:8]) << 1);
        end
        7'h33: fmt = FMT_R;
        default: ill = 1'b1;
      endcase
    end
  endfunction

  // scoreboard: compare outputs against the head of exp_q
  task automatic check_outputs();
    logic [31:0] hp, hi, ei;
    logic [2:0]  ef;
    logic        el;
    chk("valid_o", valid_o, exp_q.size() > 0);
    chk("ready_o", ready_o, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      {hp, hi} = exp_q[0];
      ref_decode(hi, ef, ei, el);
      chk("payload", {pc_o, insn_o, imm_o, fmt_o, illegal_o}, {hp, hi, ei, ef, el});
      chk("fields", {opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o},
          {hi[6:0], hi[11:7], hi[19:15], hi[24:20], hi[14:12], hi[31:25]});
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                       input logic r, input logic f);
    valid_i = v; pc_i = p; insn_i = i; ready_i = r; flush_i = f;
  endtask

  task automatic tick(output logic acc, output logic xf, output logic [63:0] popped);
    check_outputs();
    acc    = valid_i && (exp_q.size() < 2);
    xf     = (exp_q.size() > 0) && ready_i && !flush_i;
    popped = '0;
    @(posedge clk);
    if (flush_i) begin
      exp_q.delete();
      acc = 1'b0;
    end else begin
      if (xf) popped = exp_q.pop_front();
      if (acc) exp_q.push_back({pc_i, insn_i});
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_data", {pc_o, insn_o, imm_o, illegal_o}, 0);
    chk("rst_fields", {opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o}, 0);
    chk("rst_fmt", fmt_o, FMT_NONE);
    rst = 1'b1;
    @(negedge clk);

    // test-plan vectors, one per cycle with ready_i high
    drive(1, 32'h0100_0000, 32'h0050_0093, 1, 0);
    tick(a, x, pp);
    chk("addi_valid", valid_o, 1);
    chk("addi_dec", {opcode_o, rd_o, rs1_o, imm_o, fmt_o, illegal_o},
        {7'h13, 5'd1, 5'd0, 32'h0000_0005, FMT_I, 1'b0});
    drive(1, 32'h0100_0004, 32'hFE00_0EE3, 1, 0);
    tick(a, x, pp);
    chk("beq_dec", {rs1_o, rs2_o, imm_o, fmt_o}, {5'd0, 5'd0, 32'hFFFF_FFFC, FMT_B});
    drive(1, 32'h0100_0008, 32'h1234_52B7, 1, 0);
    tick(a, x, pp);
    chk("lui_dec", {rd_o, imm_o, fmt_o}, {5'd5, 32'h1234_5000, FMT_U});
    drive(1, 32'h0100_000C, 32'h0000_0000, 1, 0);
    tick(a, x, pp);
    chk("illegal_dec", {valid_o, illegal_o, imm_o, fmt_o}, {1'b1, 1'b1, 32'd0, FMT_NONE});
    drive(0, 0, 0, 1, 0);
    tick(a, x, pp);

    // back-pressure: four instructions, ready_i low for three cycles
    got_q.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      drive(idx < 4, 32'(idx * 4), 32'h0000_0013 | (32'(idx) << 7), c >= 3, 0);
      if (c == 2) chk("bp_ready_low", ready_o, 0);
      tick(a, x, pp);
      if (a) idx++;
      if (x) got_q.push_back(pp[63:32]);
    end
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < got_q.size() && k < 4; k++) chk("bp_order", got_q[k], 32'(k * 4));

    // flush with both slots full, then with one slot full and ready_o high
    drive(1, 32'h100, rand_insn(), 0, 0); tick(a, x, pp);
    drive(1, 32'h104, rand_insn(), 0, 0); tick(a, x, pp);
    drive(1, 32'h108, rand_insn(), 0, 1); tick(a, x, pp);
    chk("flush_valid", valid_o, 0);
    chk("flush_ready", ready_o, 1);
    drive(1, 32'h110, rand_insn(), 0, 0); tick(a, x, pp);
    drive(1, 32'h114, rand_insn(), 0, 1); tick(a, x, pp);
    chk("flush_no_capture", valid_o, 0);
    drive(0, 0, 0, 1, 0); tick(a, x, pp);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC, rand_insn(),
            $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      tick(a, x, pp);
    end

    // reset between edges with both slots full
    drive(1, 32'h200, rand_insn(), 0, 0); tick(a, x, pp);
    drive(1, 32'h204, rand_insn(), 0, 0); tick(a, x, pp);
    drive(0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("amid_rst_valid", valid_o, 0);
    chk("amid_rst_ready", ready_o, 1);
    chk("amid_rst_data", {pc_o, insn_o, imm_o, fmt_o, illegal_o}, {96'd0, FMT_NONE, 1'b0});
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      drive($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, rand_insn(),
            $urandom_range(0, 1), 0);
      tick(a, x, pp);
    end
    drive(0, 0, 0, 1, 0);
    repeat (4) tick(a, x, pp);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
